reg_file_arbiter: RTL and testbench

REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

---
 rtl/reg_file_arbiter_if.sv | 61 ++++++
 rtl/reg_file_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_file_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_arbiter_if.sv
// rtl/reg_file_arbiter_if.sv - signal bundle between requesters, read port, register file and PC
//
// Purpose: groups every non-clock/reset signal of reg_file_arbiter.
// Modports:
//    slave  - arbiter side (reg_file_arbiter)
//    master - environment side (requesters, read client, register file, PC sink)
// Signal groups:
//    wr_valid/wr_addr/wr_data/wr_ready     NUM_WR write requesters, requester i in slice i
//    rd_req/rd_a1/rd_a2/rd_ack             two-register read request
//    rd_valid/rd_data1/rd_data2            read response, one cycle after rd_ack
//    rf_a1/rf_a2/rf_a3/rf_wd3/rf_we3       register-file address/write port
//    rf_rd1/rf_rd2                         register-file registered read data
//    pc_wr_valid/pc_wr_data                writes addressed to r15, redirected to the PC
interface reg_file_arbiter_if #(
   parameter int NUM_WR = 3,
   parameter int DATA_W = 32
);
   logic [NUM_WR-1:0]        wr_valid;
   logic [4*NUM_WR-1:0]      wr_addr;
   logic [DATA_W*NUM_WR-1:0] wr_data;
   logic [NUM_WR-1:0]        wr_ready;

   logic                     rd_req;
   logic [3:0]               rd_a1;
   logic [3:0]               rd_a2;
   logic                     rd_ack;
   logic                     rd_valid;
   logic [DATA_W-1:0]        rd_data1;
   logic [DATA_W-1:0]        rd_data2;

   logic [3:0]               rf_a1;
   logic [3:0]               rf_a2;
   logic [3:0]               rf_a3;
   logic [DATA_W-1:0]        rf_wd3;
   logic                     rf_we3;
   logic [DATA_W-1:0]        rf_rd1;
   logic [DATA_W-1:0]        rf_rd2;

   logic                     pc_wr_valid;
   logic [DATA_W-1:0]        pc_wr_data;

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      output wr_ready,
      input  rd_req, rd_a1, rd_a2,
      output rd_ack, rd_valid, rd_data1, rd_data2,
      output rf_a1, rf_a2, rf_a3, rf_wd3, rf_we3,
      input  rf_rd1, rf_rd2,
      output pc_wr_valid, pc_wr_data
   );

   modport master (
      output wr_valid, wr_addr, wr_data,
      input  wr_ready,
      output rd_req, rd_a1, rd_a2,
      input  rd_ack, rd_valid, rd_data1, rd_data2,
      input  rf_a1, rf_a2, rf_a3, rf_wd3, rf_we3,
      output rf_rd1, rf_rd2,
      input  pc_wr_valid, pc_wr_data
   );
endinterface

// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - shares one register-file port between a reader and NUM_WR writers
//
// Purpose: a two-register read has priority in IDLE and completes one cycle later
// (RD_RESP); writers are granted in any cycle not taken by a read acceptance, so a
// continuous reader still leaves every other cycle for writes. Writes to r15 are
// redirected to the PC port instead of the register file.
// Ports:
//    clk    - sole clock, rising edge
//    reset  - synchronous, active-high; also forces every output to 0 while asserted
//    bus    - reg_file_arbiter_if.slave bundle (write requesters, read port, RF, PC)
// Configuration:
//    RF_ARB_ROUND_ROBIN_EN - when defined, writers are arbitrated round-robin from a
//                            pointer; otherwise fixed priority, lowest index wins.
module reg_file_arbiter #(
   parameter int NUM_WR = 3,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               reset,
   reg_file_arbiter_if.slave bus
);

   localparam int PTR_W = (NUM_WR > 2) ? 2 : 1;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RD_RESP = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [3:0]        w_addr_arr [NUM_WR];
   logic [DATA_W-1:0] w_data_arr [NUM_WR];

   logic [PTR_W-1:0]  w_idx;
   logic              w_grant_found;
   logic [PTR_W-1:0]  w_grant_idx;
   logic              w_grant;

`ifdef RF_ARB_ROUND_ROBIN_EN
   logic [PTR_W-1:0]  r_ptr;
`endif

   // Unpack the flat requester buses so the winner can be selected by index.
   always_comb begin
      for (int i = 0; i < NUM_WR; i++) begin
         w_addr_arr[i] = bus.wr_addr[4*i +: 4];
         w_data_arr[i] = bus.wr_data[DATA_W*i +: DATA_W];
      end
   end

   // Winner search: first requester with wr_valid, scanning from the pointer
   // (round-robin) or from index 0 (fixed priority).
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_idx         = '0;
      for (int k = 0; k < NUM_WR; k++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
         w_idx = PTR_W'((k + int'(r_ptr)) % NUM_WR);
`else
         w_idx = PTR_W'(k);
`endif
         if (!w_grant_found && bus.wr_valid[w_idx]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = w_idx;
         end
      end
   end

   // Next state and all outputs. Outputs are held at 0 while reset is high so that
   // neither a pending read response nor a grant escapes during reset.
   always_comb begin
      w_state_nxt     = r_state;
      w_grant         = 1'b0;
      bus.wr_ready    = '0;
      bus.rd_ack      = 1'b0;
      bus.rd_valid    = 1'b0;
      bus.rd_data1    = '0;
      bus.rd_data2    = '0;
      bus.rf_a1       = 4'h0;
      bus.rf_a2       = 4'h0;
      bus.rf_a3       = 4'h0;
      bus.rf_wd3      = '0;
      bus.rf_we3      = 1'b0;
      bus.pc_wr_valid = 1'b0;
      bus.pc_wr_data  = '0;

      if (!reset) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.rd_req) begin
                  bus.rd_ack  = 1'b1;
                  bus.rf_a1   = bus.rd_a1;
                  bus.rf_a2   = bus.rd_a2;
                  w_state_nxt = ST_RD_RESP;
               end else begin
                  w_grant = w_grant_found;
               end
            end
            ST_RD_RESP: begin
               // rf_rd1/rf_rd2 were registered at the acceptance edge, so a write
               // granted now cannot disturb this cycle's read data.
               bus.rd_valid = 1'b1;
               bus.rd_data1 = bus.rf_rd1;
               bus.rd_data2 = bus.rf_rd2;
               w_grant      = w_grant_found;
               w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase

         if (w_grant) begin
            bus.wr_ready[w_grant_idx] = 1'b1;
            if (w_addr_arr[w_grant_idx] == 4'hF) begin
               bus.pc_wr_valid = 1'b1;
               bus.pc_wr_data  = w_data_arr[w_grant_idx];
            end else begin
               bus.rf_we3 = 1'b1;
               bus.rf_a3  = w_addr_arr[w_grant_idx];
               bus.rf_wd3 = w_data_arr[w_grant_idx];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef RF_ARB_ROUND_ROBIN_EN
   // Pointer moves just past the last winner; unchanged when nothing is granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         if (w_grant_idx == PTR_W'(NUM_WR - 1)) begin
            r_ptr <= '0;
         end else begin
            r_ptr <= w_grant_idx + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb/tb_reg_file_arbiter.sv - scoreboard bench for reg_file_arbiter
module tb_reg_file_arbiter;

   localparam int NUM_WR = 3;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic reset;
   logic rf_init;

   always #5 clk = ~clk;

   reg_file_arbiter_if #(.NUM_WR(NUM_WR), .DATA_W(DATA_W)) bus ();

   reg_file_arbiter #(.NUM_WR(NUM_WR), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [NUM_WR-1:0] wr_ready;
      logic              rd_ack;
      logic              rd_valid;
      logic [DATA_W-1:0] rd_data1;
      logic [DATA_W-1:0] rd_data2;
      logic [3:0]        rf_a1;
      logic [3:0]        rf_a2;
      logic [3:0]        rf_a3;
      logic [DATA_W-1:0] rf_wd3;
      logic              rf_we3;
      logic              pc_wr_valid;
      logic [DATA_W-1:0] pc_wr_data;
   } exp_t;

   exp_t                  exp_q [$];
   exp_t                  mon_e;
   logic [2*DATA_W-1:0]   rd_pend [$];
   logic [DATA_W-1:0]     mdl_rf [16];
   logic [DATA_W-1:0]     tb_rf  [16];
   int                    mdl_ptr;
   int                    checks   = 0;
   int                    failures = 0;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      if (i == 15) return 32'h0000_0100;
      return 32'h0101_0101 * i;
   endfunction

   // Environment register file: registered reads, write on rf_we3.
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 16; i++) tb_rf[i] <= init_val(i);
      end else begin
         bus.rf_rd1 <= tb_rf[bus.rf_a1];
         bus.rf_rd2 <= tb_rf[bus.rf_a2];
         if (bus.rf_we3) tb_rf[bus.rf_a3] <= bus.rf_wd3;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   // Monitor: every cycle the DUT presents a full set of outputs; compare against
   // the oldest outstanding expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("wr_ready",    64'(bus.wr_ready),    64'(mon_e.wr_ready));
         chk("rd_ack",      64'(bus.rd_ack),      64'(mon_e.rd_ack));
         chk("rd_valid",    64'(bus.rd_valid),    64'(mon_e.rd_valid));
         chk("rd_data1",    64'(bus.rd_data1),    64'(mon_e.rd_data1));
         chk("rd_data2",    64'(bus.rd_data2),    64'(mon_e.rd_data2));
         chk("rf_a1",       64'(bus.rf_a1),       64'(mon_e.rf_a1));
         chk("rf_a2",       64'(bus.rf_a2),       64'(mon_e.rf_a2));
         chk("rf_a3",       64'(bus.rf_a3),       64'(mon_e.rf_a3));
         chk("rf_wd3",      64'(bus.rf_wd3),      64'(mon_e.rf_wd3));
         chk("rf_we3",      64'(bus.rf_we3),      64'(mon_e.rf_we3));
         chk("pc_wr_valid", 64'(bus.pc_wr_valid), 64'(mon_e.pc_wr_valid));
         chk("pc_wr_data",  64'(bus.pc_wr_data),  64'(mon_e.pc_wr_data));
      end
   end

   // One clock cycle of stimulus plus the reference model's view of that cycle.
   // Model rules: at most one read in flight; a read returns register contents as
   // of its acceptance one cycle later; any cycle that is not a read acceptance may
   // grant one writer; r15 writes go to the PC; reset drops everything.
   task automatic drive_cycle(input logic rst, input logic [NUM_WR-1:0] wv,
                              input logic [4*NUM_WR-1:0] wa,
                              input logic [DATA_W*NUM_WR-1:0] wd,
                              input logic rq, input logic [3:0] a1, input logic [3:0] a2);
      exp_t              e;
      bit                slot;
      int                w;
      int                idx;
      logic [3:0]        waddr;
      logic [DATA_W-1:0] wdata;

      @(posedge clk);
      #1;
      reset        = rst;
      bus.wr_valid = wv;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.rd_req   = rq;
      bus.rd_a1    = a1;
      bus.rd_a2    = a2;

      e     = '0;
      slot  = 1'b0;
      w     = -1;
      waddr = '0;
      wdata = '0;
      if (!rst) begin
         if (rd_pend.size() > 0) begin
            e.rd_valid = 1'b1;
            {e.rd_data1, e.rd_data2} = rd_pend[0];
            slot = 1'b1;
         end else if (rq) begin
            e.rd_ack = 1'b1;
            e.rf_a1  = a1;
            e.rf_a2  = a2;
         end else begin
            slot = 1'b1;
         end
         if (slot) begin
            for (int k = 0; k < NUM_WR; k++) begin
               idx = (mdl_ptr + k) % NUM_WR;
               if (w < 0 && wv[idx]) w = idx;
            end
            if (w >= 0) begin
               waddr = wa[4*w +: 4];
               wdata = wd[DATA_W*w +: DATA_W];
               e.wr_ready[w] = 1'b1;
               if (waddr == 4'hF) begin
                  e.pc_wr_valid = 1'b1;
                  e.pc_wr_data  = wdata;
               end else begin
                  e.rf_we3 = 1'b1;
                  e.rf_a3  = waddr;
                  e.rf_wd3 = wdata;
               end
            end
         end
      end
      exp_q.push_back(e);

      if (rst) begin
         rd_pend.delete();
         mdl_ptr = 0;
      end else begin
         if (rd_pend.size() > 0) void'(rd_pend.pop_front());
         else if (rq) rd_pend.push_back({mdl_rf[a1], mdl_rf[a2]});
         if (w >= 0) begin
            if (waddr != 4'hF) mdl_rf[waddr] = wdata;
`ifdef RF_ARB_ROUND_ROBIN_EN
            mdl_ptr = (w + 1) % NUM_WR;
`endif
         end
      end
   endtask

   initial begin
      logic [4*NUM_WR-1:0]      ra;
      logic [DATA_W*NUM_WR-1:0] rdat;
      logic [3:0]               na;

      reset        = 1'b1;
      rf_init      = 1'b1;
      bus.wr_valid = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.rd_req   = 1'b0;
      bus.rd_a1    = '0;
      bus.rd_a2    = '0;
      mdl_ptr      = 0;
      for (int i = 0; i < 16; i++) mdl_rf[i] = init_val(i);
      @(posedge clk);
      #1 rf_init = 1'b0;

      // Reset state
      drive_cycle(1'b1, '0, '0, '0, 1'b0, 4'h0, 4'h0);
      drive_cycle(1'b1, 3'b111, 12'hFFF, {3{32'hFFFF_FFFF}}, 1'b1, 4'h1, 4'h2);

      // Single write of 0xDEADBEEF to r3 from requester 0
      drive_cycle(1'b0, 3'b001, 12'h003, {32'h0, 32'h0, 32'hDEAD_BEEF}, 1'b0, 4'h0, 4'h0);
      // Read r3 and r15, then the response cycle
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'h3, 4'hF);
      drive_cycle(1'b0, '0, '0, '0, 1'b0, 4'h0, 4'h0);

      // Continuous reads with one writer: writes interleave in response cycles
      for (int i = 0; i < 6; i++)
         drive_cycle(1'b0, 3'b001, 12'h005, {64'h0, 32'h5000 + 32'(i)}, 1'b1, 4'h5, 4'(i));
      drive_cycle(1'b0, '0, '0, '0, 1'b0, 4'h0, 4'h0);

      // All three writers held for six cycles
      for (int i = 0; i < 6; i++)
         drive_cycle(1'b0, 3'b111, 12'h987, {32'hC0 + 32'(i), 32'hB0 + 32'(i), 32'hA0 + 32'(i)},
                     1'b0, 4'h0, 4'h0);

      // Write to r15 goes to the PC
      drive_cycle(1'b0, 3'b010, 12'h0F0, {32'h0, 32'h8000, 32'h0}, 1'b0, 4'h0, 4'h0);

      // Reset during the acceptance cycle, then during the response cycle
      drive_cycle(1'b1, '0, '0, '0, 1'b1, 4'h7, 4'h8);
      drive_cycle(1'b0, '0, '0, '0, 1'b0, 4'h0, 4'h0);
      drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'h7, 4'h8);
      drive_cycle(1'b1, 3'b100, 12'h100, {32'h1234, 64'h0}, 1'b0, 4'h0, 4'h0);
      drive_cycle(1'b0, '0, '0, '0, 1'b0, 4'h0, 4'h0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int r = 0; r < NUM_WR; r++) begin
            na = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            ra[4*r +: 4]           = na;
            rdat[DATA_W*r +: DATA_W] = $urandom;
         end
         drive_cycle(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)), ra, rdat,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      drive_cycle(1'b0, '0, '0, '0, 1'b0, 4'h0, 4'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
